// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI padding block.
//   coord_t   : 16-bit unsigned pixel coordinate / frame dimension
//   pixel_t   : fixed-point pixel, sign + integer + fraction bits
//   state_t   : padding controller states
//   roi_cfg_t : frame size, inclusive ROI bounds and fill value, latched per frame
package roi_pkg;

    localparam int FP_S  = 1;
    localparam int FP_M  = 7;
    localparam int FP_N  = 8;
    localparam int PIX_W = FP_M + FP_N + FP_S;

    localparam int FIFO_DEPTH_DEF = 16;

    typedef logic [15:0]      coord_t;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        coord_t rows;
        coord_t cols;
        coord_t row_start;
        coord_t row_end;
        coord_t col_start;
        coord_t col_end;
        pixel_t fill;
    } roi_cfg_t;

    // An ROI is usable only if it is non-empty and lies fully inside the frame.
    // A zero-sized frame fails the end < size tests automatically.
    function automatic logic roi_valid(input roi_cfg_t cfg);
        return (cfg.row_start <= cfg.row_end) &&
               (cfg.col_start <= cfg.col_end) &&
               (cfg.row_end   <  cfg.rows)    &&
               (cfg.col_end   <  cfg.cols);
    endfunction

endpackage

// File: rtl/roi_pad_if.sv
// Pixel stream interface: one pixel per valid cycle with its row/col.
//   clk   : stream clock (only consumed on the writer side)
//   valid : pixel qualifier
//   row   : pixel row
//   col   : pixel column
//   pixel : pixel value
// writer : view of the block that is written into (all signals inputs)
// reader : view of the block that produces the stream (all signals outputs)
interface pixel_data_interface;

    logic            clk;
    logic            valid;
    roi_pkg::coord_t row;
    roi_pkg::coord_t col;
    roi_pkg::pixel_t pixel;

    modport writer (input clk, input valid, input row, input col, input pixel);
    modport reader (output valid, output row, output col, output pixel);

endinterface

// File: rtl/roi_pad_fifo.sv
// Synchronous single-clock pixel buffer between the ROI input stream and
// the output raster.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the buffer; a push on the same edge is kept as the
//                only entry
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request and head-of-queue data
//   full/empty : occupancy flags
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_addr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees the head on the same edge, so a full buffer still accepts.
    assign do_push = push && (flush || !full || pop);
    assign do_pop  = pop && !empty && !flush;
    assign wr_addr = flush ? '0 : wr_ptr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/roi_pad.sv
// Places a cropped ROI pixel stream into a full output frame, padding every
// position outside the ROI with a fill value.
//   in           : cropped ROI stream and the block clock (in.clk)
//   rst_n_i      : asynchronous active-low reset
//   out          : full-frame raster stream, absolute row/col
//   frame_*_i    : output frame size in pixels
//   row/col_*_i  : inclusive ROI bounds within the output frame
//   fill_i       : pixel emitted outside the ROI
//   busy_o       : frame in progress
//   overflow_o   : sticky, an ROI pixel was dropped on a full buffer
//
// state | meaning
// IDLE  | waiting for a start pixel (valid at row 0, col 0)
// RUN   | walking the output raster, emitting fill or buffered ROI pixels
module roi_pad
    import roi_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    pixel_data_interface.writer in,
    input  logic                rst_n_i,
    pixel_data_interface.reader out,
    input  coord_t              frame_rows_i,
    input  coord_t              frame_cols_i,
    input  coord_t              row_start_i,
    input  coord_t              row_end_i,
    input  coord_t              col_start_i,
    input  coord_t              col_end_i,
    input  pixel_t              fill_i,
    output logic                busy_o,
    output logic                overflow_o
);

    logic     clk;
    state_t   state_q, state_d;
    roi_cfg_t cfg_q, cfg_in;
    coord_t   r_q, c_q;
    logic     armed_q;

    logic     out_valid_q;
    coord_t   out_row_q, out_col_q;
    pixel_t   out_pixel_q;
    logic     overflow_q;

    logic     start_hit, cfg_ok, in_roi, emit, pop, last_px, eof, restart, push;
    pixel_t   fifo_dout;
    logic     fifo_full, fifo_empty;

    assign clk = in.clk;

    always_comb begin
        cfg_in           = '0;
        cfg_in.rows      = frame_rows_i;
        cfg_in.cols      = frame_cols_i;
        cfg_in.row_start = row_start_i;
        cfg_in.row_end   = row_end_i;
        cfg_in.col_start = col_start_i;
        cfg_in.col_end   = col_end_i;
        cfg_in.fill      = fill_i;
    end

    always_comb begin
        start_hit = in.valid && (in.row == '0) && (in.col == '0) &&
                    (frame_rows_i != '0) && (frame_cols_i != '0);
        cfg_ok    = roi_valid(cfg_q);
        in_roi    = cfg_ok &&
                    (r_q >= cfg_q.row_start) && (r_q <= cfg_q.row_end) &&
                    (c_q >= cfg_q.col_start) && (c_q <= cfg_q.col_end);
        // Fill positions never wait on the buffer; ROI positions stall until data arrives.
        emit      = (state_q == ST_RUN) && armed_q && (!in_roi || !fifo_empty);
        pop       = emit && in_roi;
        last_px   = (r_q == cfg_q.rows - 16'd1) && (c_q == cfg_q.cols - 16'd1);
        eof       = emit && last_px;
        // A start pixel on the end-of-frame edge begins the next frame directly.
        restart   = start_hit && ((state_q == ST_IDLE) || eof);

        state_d = state_q;
        if (eof) begin
            state_d = ST_IDLE;
        end
        if (restart) begin
            state_d = ST_RUN;
        end

        push = 1'b0;
        if (restart) begin
            push = roi_valid(cfg_in);
        end else if ((state_q == ST_RUN) && !eof) begin
            push = in.valid && cfg_ok;
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n_i),
        .flush (eof),
        .push  (push),
        .pop   (pop),
        .din   (in.pixel),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            armed_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_pixel_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (push && fifo_full && !pop && !eof) begin
                overflow_q <= 1'b1;
            end

            // armed_q holds off the raster for the first RUN cycle so the first
            // output lands two edges after the start pixel is sampled.
            if (restart) begin
                cfg_q   <= cfg_in;
                r_q     <= '0;
                c_q     <= '0;
                armed_q <= 1'b0;
            end else begin
                armed_q <= (state_q == ST_RUN) && !eof;
                if (emit) begin
                    if (c_q == cfg_q.cols - 16'd1) begin
                        c_q <= '0;
                        r_q <= last_px ? '0 : r_q + 16'd1;
                    end else begin
                        c_q <= c_q + 16'd1;
                    end
                end
            end

            out_valid_q <= emit;
            if (emit) begin
                out_row_q   <= r_q;
                out_col_q   <= c_q;
                out_pixel_q <= in_roi ? fifo_dout : cfg_q.fill;
            end
        end
    end

    assign out.valid  = out_valid_q;
    assign out.row    = out_row_q;
    assign out.col    = out_col_q;
    assign out.pixel  = out_pixel_q;
    assign busy_o     = (state_q == ST_RUN);
    assign overflow_o = overflow_q;

endmodule

// File: doc/roi_pad.md
ROI_PAD -- requirements
Module: roi_pad

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, power-of-two depth of the ROI pixel buffer.
REQ-002 SHALL have port in.clk  input  1  single clock, carried on the in interface; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in  pixel_data_interface.writer  --  cropped ROI stream: valid, row, col (16b each), pixel (FP_M+FP_N+FP_S bits).
REQ-005 SHALL have port out  pixel_data_interface.reader  --  full-frame stream; row, col absolute.
REQ-006 SHALL have ports frame_rows_i, frame_cols_i  input  16 each  full output frame size in pixels (count, not last index).
REQ-007 SHALL have ports row_start_i, row_end_i, col_start_i, col_end_i  input  16 each  inclusive ROI placement in the output frame.
REQ-008 SHALL have port fill_i  input  pixel width  value emitted outside the ROI.
REQ-009 SHALL have port busy_o  output  1  high while in RUN.
REQ-010 SHALL have port overflow_o  output  1  sticky; set when an input pixel is dropped.

Function
REQ-011 SHALL implement FSM states IDLE and RUN.
REQ-012 IDLE -> RUN when in.valid=1, in.row=0, in.col=0; same edge latches all frame/ROI/fill inputs and pushes that pixel.
REQ-013 Latched configuration SHALL stay constant for the whole frame; input changes take effect only at the next IDLE -> RUN.
REQ-014 In RUN the block SHALL keep an output raster (r,c), starting at (0,0), advancing column-major-inner (c first, wrap to 0 and r+1 at c=frame_cols-1).
REQ-015 Raster outside ROI: emit fill pixel at (r,c) and advance, every cycle, with no dependence on the FIFO.
REQ-016 Raster inside ROI: if FIFO non-empty, pop head, emit it at (r,c), advance; if empty, out.valid=0 and raster holds.
REQ-017 Outputs SHALL be registered; out.valid for raster (0,0) rises exactly 2 edges after the edge sampling the start pixel.
REQ-018 In RUN every in.valid=1 pixel SHALL be pushed regardless of its row/col; pixels arriving in IDLE other than the start pixel are discarded without setting overflow_o.
REQ-019 Push on full FIFO: pixel dropped, overflow_o set; push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-020 Emission of (frame_rows-1, frame_cols-1) SHALL return FSM to IDLE on that edge and flush the FIFO; leftover pixels are discarded.
REQ-021 A start pixel arriving in the same cycle as end-of-frame SHALL be honoured (flush, then push it, RUN).
REQ-022 Invalid latched ROI (start>end, row_end>=frame_rows, or col_end>=frame_cols) SHALL yield an all-fill frame and no pushes.
REQ-023 Raster counters and comparisons SHALL be 16-bit unsigned; frame_rows or frame_cols of 0 SHALL keep the block in IDLE.

Reset
REQ-024 rst_n_i low SHALL asynchronously force IDLE, empty FIFO, out.valid=0, out.row=0, out.col=0, out.pixel=0, busy_o=0, overflow_o=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a new start pixel.
REQ-026 Latched configuration SHALL reset to frame 0x0 and ROI 0..0; it is unused until the next latch.

Structure
REQ-027 State enum, FIFO_DEPTH default and 16-bit coordinate type SHALL live in shared package roi_pkg.
REQ-028 Buffer SHALL be a separate sub-module pixel_fifo (synchronous, one clock, async active-low reset, flush input, full/empty outputs).

Verification
REQ-029 Frame 8x6, ROI rows 2..4 cols 1..3, 9 ROI pixels at 1/cycle -> 48 outputs, fill outside, ROI pixels in order at (2..4,1..3), busy_o falls after (7,5).
REQ-030 Same frame, ROI pixels 1 every 5 cycles -> out.valid gaps only at ROI positions, no dropped data, overflow_o=0.
REQ-031 FIFO_DEPTH=4, frame 4x4, ROI rows 2..3 cols 0..3 fed as 8-cycle burst at start -> overflow_o=1 and dropped pixels absent from output.
REQ-032 Change row_start_i mid-frame -> current frame unchanged; next frame uses new placement.
REQ-033 row_end_i=9 with frame_rows=8 -> all 48 outputs equal fill_i.
REQ-034 Assert rst_n_i at raster (3,2) -> outputs zero immediately (no clock edge); next start pixel restarts at (0,0).
